// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl: measures line width, drives shift_line taps and tracks the 3x3 window centre
module line_buf_ctrl #(
  parameter int DATA_WIDTH = 24,
  parameter int MAX_WIDTH  = 2048,
  parameter int MIN_WIDTH  = 4
) (
  input  logic                  clock,
  input  logic                  aclr_n,
  input  logic                  vs_in,
  input  logic                  de_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  lb_aclr,
  output logic                  lb_clken,
  output logic [DATA_WIDTH-1:0] lb_shiftin,
  output logic [15:0]           lb_delay_num,
  output logic                  win_de,
  output logic [11:0]           win_x,
  output logic [11:0]           win_y,
  output logic                  win_left,
  output logic                  win_right,
  output logic                  win_top,
  output logic                  win_bottom,
  output logic                  busy,
  output logic                  err_len
);
  typedef enum logic [1:0] {IDLE, MEASURE, RUN, FLUSH} state_t;
  localparam logic [15:0] MAXW = 16'(MAX_WIDTH);
  localparam logic [15:0] MINW = 16'(MIN_WIDTH);
  state_t r_state, w_state;
  logic r_vs_d, r_de_d, r_arm;
  logic [15:0] r_wcnt, w_wcnt, r_xcnt, w_xcnt, r_width, w_width;
  logic [11:0] r_line, w_line;
  logic r_aclr, r_clken, r_de, r_left, r_right, r_top, r_bottom, r_err;
  logic [DATA_WIDTH-1:0] r_shift, w_shift;
  logic [11:0] r_x, r_y, w_x, w_y;
  logic w_aclr, w_clken, w_de, w_bottom, w_err;
  logic w_vs_rise, w_de_rise, w_de_fall;
  logic [15:0] w_wm1, w_xinc;
  // r_arm blocks a line already in progress at reset release from looking like a rising edge
  assign w_vs_rise = vs_in & ~r_vs_d;
  assign w_de_rise = de_in & ~r_de_d & r_arm;
  assign w_de_fall = ~de_in & r_de_d;
  assign w_wm1     = r_width - 16'd1;
  assign w_xinc    = (r_xcnt == 16'hFFFF) ? r_xcnt : r_xcnt + 16'd1;
  // next-state, counters and next output values; vs edge outranks de edges
  always_comb begin
    w_state  = r_state;
    w_wcnt   = r_wcnt;
    w_xcnt   = r_xcnt;
    w_width  = r_width;
    w_line   = r_line;
    w_err    = r_err;
    w_aclr   = 1'b0;
    w_clken  = 1'b0;
    w_shift  = '0;
    w_de     = 1'b0;
    w_x      = '0;
    w_y      = '0;
    w_bottom = 1'b0;
    if (w_vs_rise) begin
      w_state = (r_state == RUN) ? FLUSH : IDLE;
      w_xcnt  = '0;
      w_wcnt  = (r_state == RUN) ? r_wcnt : '0;
      w_line  = (r_state == RUN) ? r_line : '0;
    end else if ((r_state == IDLE || r_state == FLUSH) && w_de_rise) begin
      w_state = MEASURE;
      w_aclr  = 1'b1;
      w_clken = 1'b1;
      w_shift = data_in;
      w_wcnt  = 16'd1;
      w_xcnt  = '0;
      w_line  = '0;
      w_err   = r_err | (r_state == FLUSH);
    end else if (r_state == MEASURE) begin
      if (de_in) begin
        w_clken = 1'b1;
        w_shift = data_in;
        w_wcnt  = (r_wcnt == 16'hFFFF) ? r_wcnt : r_wcnt + 16'd1;
      end else if (w_de_fall) begin
        if (r_wcnt >= MINW && r_wcnt <= MAXW) begin
          w_width = r_wcnt;
          w_line  = 12'd1;
          w_state = RUN;
        end else begin
          w_err   = 1'b1;
          w_state = IDLE;
        end
        w_wcnt = '0;
        w_xcnt = '0;
      end
    end else if (r_state == RUN) begin
      w_y = r_line - 12'd1;
      if (de_in) begin
        w_xcnt  = w_xinc;
        w_de    = r_xcnt < r_width;
        w_clken = w_de;
        w_shift = w_de ? data_in : '0;
        w_x     = w_de ? r_xcnt[11:0] : w_wm1[11:0];
      end else if (w_de_fall) begin
        w_err  = r_err | (r_xcnt != r_width);
        w_line = (r_line == 12'hFFF) ? r_line : r_line + 12'd1;
        w_xcnt = '0;
      end
    end else if (r_state == FLUSH) begin
      w_clken  = 1'b1;
      w_de     = 1'b1;
      w_bottom = 1'b1;
      w_x      = r_xcnt[11:0];
      w_y      = r_line - 12'd1;
      w_xcnt   = (r_xcnt == w_wm1) ? '0 : w_xinc;
      w_line   = (r_xcnt == w_wm1) ? '0 : r_line;
      w_state  = (r_xcnt == w_wm1) ? IDLE : FLUSH;
    end
  end
  // state, counters, edge detectors and registered outputs
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state  <= IDLE;
      r_vs_d   <= 1'b0;
      r_de_d   <= 1'b0;
      r_arm    <= 1'b0;
      r_wcnt   <= '0;
      r_xcnt   <= '0;
      r_width  <= MAXW;
      r_line   <= '0;
      r_aclr   <= 1'b0;
      r_clken  <= 1'b0;
      r_shift  <= '0;
      r_de     <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_left   <= 1'b0;
      r_right  <= 1'b0;
      r_top    <= 1'b0;
      r_bottom <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_vs_d   <= vs_in;
      r_de_d   <= de_in;
      r_arm    <= r_arm | ~de_in;
      r_wcnt   <= w_wcnt;
      r_xcnt   <= w_xcnt;
      r_width  <= w_width;
      r_line   <= w_line;
      r_aclr   <= w_aclr;
      r_clken  <= w_clken;
      r_shift  <= w_shift;
      r_de     <= w_de;
      r_x      <= w_x;
      r_y      <= w_y;
      r_left   <= w_de && w_x == 12'd0;
      r_right  <= w_de && {4'd0, w_x} == w_wm1;
      r_top    <= w_de && w_y == 12'd0;
      r_bottom <= w_bottom;
      r_err    <= w_err;
    end
  end
  assign lb_aclr      = r_aclr;
  assign lb_clken     = r_clken;
  assign lb_shiftin   = r_shift;
  assign lb_delay_num = r_width;
  assign win_de       = r_de;
  assign win_x        = r_x;
  assign win_y        = r_y;
  assign win_left     = r_left;
  assign win_right    = r_right;
  assign win_top      = r_top;
  assign win_bottom   = r_bottom;
  assign busy         = r_state != IDLE;
  assign err_len      = r_err;
endmodule

// File: tb/tb_line_buf_ctrl.sv
// tb_line_buf_ctrl: directed scenario tests for line_buf_ctrl
module tb_line_buf_ctrl;
  logic clock = 1'b0;
  logic aclr_n, vs_in, de_in;
  logic [23:0] data_in, lb_shiftin;
  logic lb_aclr, lb_clken, win_de, win_left, win_right, win_top, win_bottom, busy, err_len;
  logic [15:0] lb_delay_num;
  logic [11:0] win_x, win_y;
  int checks = 0, errors = 0;
  int n_aclr, n_clken, n_de, n_left, n_right, n_top, n_bottom, n_bad, max_x, last_y;
  line_buf_ctrl dut (
    .clock(clock), .aclr_n(aclr_n), .vs_in(vs_in), .de_in(de_in), .data_in(data_in),
    .lb_aclr(lb_aclr), .lb_clken(lb_clken), .lb_shiftin(lb_shiftin), .lb_delay_num(lb_delay_num),
    .win_de(win_de), .win_x(win_x), .win_y(win_y), .win_left(win_left), .win_right(win_right),
    .win_top(win_top), .win_bottom(win_bottom), .busy(busy), .err_len(err_len)
  );
  always #5 clock = ~clock;
  task automatic clr();
    n_aclr = 0; n_clken = 0; n_de = 0; n_left = 0; n_right = 0;
    n_top = 0; n_bottom = 0; n_bad = 0; max_x = 0; last_y = 0;
  endtask
  // apply one cycle of inputs, then tally the outputs they produce
  task automatic cyc(input logic v, input logic d, input logic [23:0] px);
    vs_in = v; de_in = d; data_in = px;
    @(posedge clock); #1;
    n_aclr += int'(lb_aclr); n_clken += int'(lb_clken); n_de += int'(win_de);
    n_left += int'(win_left); n_right += int'(win_right);
    n_top += int'(win_top); n_bottom += int'(win_bottom);
    if (win_de && int'(win_x) > max_x) max_x = int'(win_x);
    if (win_bottom) last_y = int'(win_y);
    if (lb_clken && !win_bottom && lb_shiftin !== px) n_bad++;
    if (win_bottom && lb_shiftin !== 24'd0) n_bad++;
  endtask
  task automatic line(input int n, input int gap);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 24'(32'h100 + i));
    for (int i = 0; i < gap; i++) cyc(1'b0, 1'b0, 24'd0);
  endtask
  task automatic do_reset();
    aclr_n = 1'b0; vs_in = 1'b0; de_in = 1'b0; data_in = '0;
    repeat (2) @(posedge clock);
    #1 aclr_n = 1'b1;
    cyc(1'b0, 1'b0, 24'd0);
    cyc(1'b0, 1'b0, 24'd0);
    clr();
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({lb_aclr, lb_clken, lb_shiftin, win_de, win_x, win_y, win_left, win_right, win_top, win_bottom, busy, err_len} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    checks++;
    if (lb_delay_num !== 16'd2048) begin errors++; $display("FAIL reset_delay: got %0d required 2048", lb_delay_num); end
  endtask
  task automatic test_frame();
    do_reset();
    line(16, 4);
    checks++;
    if (lb_delay_num !== 16'd16) begin errors++; $display("FAIL frame_delay: got %0d required 16", lb_delay_num); end
    for (int l = 0; l < 7; l++) line(16, 4);
    cyc(1'b1, 1'b0, 24'd0);
    cyc(1'b1, 1'b0, 24'd0);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 24'd0);
    checks++;
    if (n_aclr !== 1) begin errors++; $display("FAIL frame_aclr: got %0d required 1", n_aclr); end
    checks++;
    if (n_de !== 128) begin errors++; $display("FAIL frame_win_de: got %0d required 128", n_de); end
    checks++;
    if (n_clken !== 144) begin errors++; $display("FAIL frame_clken: got %0d required 144", n_clken); end
    checks++;
    if (n_top !== 16 || n_bottom !== 16) begin errors++; $display("FAIL frame_top_bottom: got %0d/%0d required 16/16", n_top, n_bottom); end
    checks++;
    if (n_left !== 8 || n_right !== 8) begin errors++; $display("FAIL frame_left_right: got %0d/%0d required 8/8", n_left, n_right); end
    checks++;
    if (last_y !== 7 || max_x !== 15) begin errors++; $display("FAIL frame_xy: got y=%0d x=%0d required 7/15", last_y, max_x); end
    checks++;
    if (n_bad !== 0) begin errors++; $display("FAIL frame_shiftin: got %0d bad required 0", n_bad); end
    checks++;
    if (busy !== 1'b0 || err_len !== 1'b0) begin errors++; $display("FAIL frame_end: got busy=%b err=%b required 0/0", busy, err_len); end
  endtask
  task automatic test_short_line();
    do_reset();
    line(3, 4);
    checks++;
    if (err_len !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL short_state: got err=%b busy=%b required 1/0", err_len, busy); end
    checks++;
    if (n_clken !== 3 || n_de !== 0) begin errors++; $display("FAIL short_counts: got clken=%0d de=%0d required 3/0", n_clken, n_de); end
    checks++;
    if (lb_delay_num !== 16'd2048) begin errors++; $display("FAIL short_delay: got %0d required 2048", lb_delay_num); end
  endtask
  task automatic test_overlong();
    do_reset();
    line(16, 4);
    checks++;
    if (err_len !== 1'b0) begin errors++; $display("FAIL long_pre_err: got %b required 0", err_len); end
    clr();
    line(18, 4);
    checks++;
    if (n_clken !== 16 || n_de !== 16) begin errors++; $display("FAIL long_counts: got clken=%0d de=%0d required 16/16", n_clken, n_de); end
    checks++;
    if (n_right !== 1 || max_x !== 15) begin errors++; $display("FAIL long_right: got right=%0d maxx=%0d required 1/15", n_right, max_x); end
    checks++;
    if (err_len !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL long_err: got err=%b busy=%b required 1/1", err_len, busy); end
  endtask
  task automatic test_flush_abort();
    do_reset();
    line(16, 4);
    line(16, 4);
    cyc(1'b1, 1'b0, 24'd0);
    clr();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 24'd0);
    cyc(1'b0, 1'b1, 24'h55);
    checks++;
    if (n_bottom !== 5 || max_x !== 4) begin errors++; $display("FAIL abort_flush: got bottom=%0d maxx=%0d required 5/4", n_bottom, max_x); end
    checks++;
    if (n_aclr !== 1 || lb_aclr !== 1'b1) begin errors++; $display("FAIL abort_aclr: got %0d required 1", n_aclr); end
    checks++;
    if (err_len !== 1'b1 || busy !== 1'b1 || win_de !== 1'b0) begin errors++; $display("FAIL abort_state: got err=%b busy=%b de=%b required 1/1/0", err_len, busy, win_de); end
    line(15, 4);
    checks++;
    if (lb_delay_num !== 16'd16 || n_de !== 5 || n_clken !== 21) begin errors++; $display("FAIL abort_remeasure: got delay=%0d de=%0d clken=%0d required 16/5/21", lb_delay_num, n_de, n_clken); end
  endtask
  task automatic test_reset_midline();
    do_reset();
    line(16, 4);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 24'h77);
    aclr_n = 1'b0;
    #2;
    checks++;
    if ({lb_aclr, lb_clken, lb_shiftin, win_de, win_x, win_y, win_left, win_right, win_top, win_bottom, busy, err_len} !== '0 || lb_delay_num !== 16'd2048) begin
      errors++; $display("FAIL midreset_outputs: got delay=%0d clken=%b de=%b required 2048/0/0", lb_delay_num, lb_clken, win_de);
    end
    #1 aclr_n = 1'b1;
    clr();
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 24'h77);
    checks++;
    if (n_clken !== 0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_partial: got clken=%0d busy=%b required 0/0", n_clken, busy); end
    line(0, 2);
    line(4, 4);
    checks++;
    if (n_clken !== 4 || n_aclr !== 1 || busy !== 1'b1 || lb_delay_num !== 16'd4) begin
      errors++; $display("FAIL midreset_next: got clken=%0d aclr=%0d busy=%b delay=%0d required 4/1/1/4", n_clken, n_aclr, busy, lb_delay_num);
    end
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int l = 0; l < 3; l++) line(16, 4);
    cyc(1'b1, 1'b0, 24'd0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 24'd0);
    clr();
    for (int i = 0; i < 32; i++) cyc(1'b0, 1'b1, 24'(i));
    checks++;
    if (lb_delay_num !== 16'd16) begin errors++; $display("FAIL b2b_delay_hold: got %0d required 16", lb_delay_num); end
    line(0, 4);
    checks++;
    if (lb_delay_num !== 16'd32) begin errors++; $display("FAIL b2b_delay_new: got %0d required 32", lb_delay_num); end
    line(32, 4);
    line(32, 4);
    cyc(1'b1, 1'b0, 24'd0);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 24'd0);
    checks++;
    if (max_x !== 31 || n_right !== 3 || n_de !== 96) begin errors++; $display("FAIL b2b_window: got maxx=%0d right=%0d de=%0d required 31/3/96", max_x, n_right, n_de); end
    checks++;
    if (err_len !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_end: got err=%b busy=%b required 0/0", err_len, busy); end
  endtask
  initial begin
    test_reset();
    test_frame();
    test_short_line();
    test_overlong();
    test_flush_abort();
    test_reset_midline();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
